game_controller: RTL and testbench

Parametrised top-level game-flow controller for the brick-breaker design: replaces the fixed 6-brick START/PLAY/CHECK/WIN/LOSE sequencer with a controller that handles N bricks, multiple lives, multiple levels, pause and a saturating score. It sits between the pushbuttons and the ball/paddle/brick instances, issuing `launch`, `respawn` and `level_load` to them and `game_over`/`victory`/score to the display logic.

---
 rtl/game_controller.sv | 269 ++++++++++++++++++++++++++
 tb/tb_game_controller.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// -----------------------------------------------------------------------------
// game_controller
//
// Game-flow controller for the brick-breaker design. Tracks lives, levels,
// pause and a saturating score for N bricks, and drives the ball/paddle/brick
// instances plus the display logic.
//
// Parameters
//   N_BRICKS        number of brick instances monitored (1..32)
//   LIVES           lives at game start (1..15)
//   LEVELS          levels to clear for victory (1..16)
//   SCORE_W         score counter width
//   RESPAWN_CYCLES  cycles spent in LIFE_LOST before the ball respawns (>=1)
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   start         start button, active-low, debounced
//   pause         pause button, active-low, debounced
//   bricks_exist  bit i high while brick i is alive
//   death_zone    bit i high when brick i has reached the paddle row
//   ball_lost     ball passed below the paddle (level signal)
//   launch        high while playing; ball/paddle move only when high
//   respawn       one-cycle pulse, ball re-centres on the paddle
//   level_load    one-cycle pulse, bricks reinitialise
//   lives_left    remaining lives
//   level         current level, 0-based
//   score         bricks destroyed, saturating
//   state         current state encoding (debug)
//   game_over     high in LOSE
//   victory       high in WIN
// -----------------------------------------------------------------------------
module game_controller #(
    parameter int N_BRICKS       = 6,
    parameter int LIVES          = 3,
    parameter int LEVELS         = 4,
    parameter int SCORE_W        = 16,
    parameter int RESPAWN_CYCLES = 50000000
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic                                         pause,
    input  logic [N_BRICKS-1:0]                          bricks_exist,
    input  logic [N_BRICKS-1:0]                          death_zone,
    input  logic                                         ball_lost,
    output logic                                         launch,
    output logic                                         respawn,
    output logic                                         level_load,
    output logic [$clog2(LIVES+1)-1:0]                   lives_left,
    output logic [((LEVELS > 1) ? $clog2(LEVELS) : 1)-1:0] level,
    output logic [SCORE_W-1:0]                           score,
    output logic [2:0]                                   state,
    output logic                                         game_over,
    output logic                                         victory
);

    localparam int LIVES_W = $clog2(LIVES + 1);
    localparam int LEVEL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam int CNT_W   = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
    localparam int PC_W    = $clog2(N_BRICKS + 1);
    // Sum is wide enough to hold max score plus a full-row kill without wrap.
    localparam int SUM_W   = ((SCORE_W > PC_W) ? SCORE_W : PC_W) + 1;

    localparam logic [SUM_W-1:0] SCORE_MAX_EXT = SUM_W'({SCORE_W{1'b1}});
    localparam logic [CNT_W-1:0] CNT_RELOAD    = CNT_W'(RESPAWN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_PAUSE     = 3'd2,
        ST_LIFE_LOST = 3'd3,
        ST_LEVEL_UP  = 3'd4,
        ST_LOSE      = 3'd5,
        ST_WIN       = 3'd6
    } state_e;

    state_e               state_q, state_d;
    logic                 start_dly_q, start_dly_d;
    logic                 pause_dly_q, pause_dly_d;
    logic [N_BRICKS-1:0]  prev_q, prev_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 launch_q, launch_d;
    logic                 respawn_q, respawn_d;
    logic                 level_load_q, level_load_d;
    logic                 game_over_q, game_over_d;
    logic                 victory_q, victory_d;

    logic                 start_press;
    logic                 pause_press;
    logic                 any_death;
    logic                 all_clear;
    logic                 last_life;
    logic                 last_level;
    logic                 cnt_zero;
    logic                 play_life_loss;
    logic [PC_W-1:0]      kill_count;
    logic [SUM_W-1:0]     score_sum;

    function automatic logic [PC_W-1:0] popcount(input logic [N_BRICKS-1:0] v);
        logic [PC_W-1:0] total;
        total = '0;
        for (int i = 0; i < N_BRICKS; i++) begin
            total = total + PC_W'(v[i]);
        end
        return total;
    endfunction

    // Event decode. A press is a high-to-low edge of the active-low button
    // against its one-cycle-delayed copy, so a held button fires once only.
    // A brick kill is a 1->0 transition against last cycle's brick vector.
    always_comb begin
        start_press    = start_dly_q & ~start;
        pause_press    = pause_dly_q & ~pause;
        any_death      = |death_zone;
        all_clear      = (bricks_exist == '0);
        last_life      = (lives_q == LIVES_W'(1));
        last_level     = (level_q == LEVEL_W'(LEVELS - 1));
        cnt_zero       = (cnt_q == '0);
        // Death zone outranks ball loss, so a life is only spent without it.
        play_life_loss = (state_q == ST_PLAY) && !any_death && ball_lost;
        kill_count     = popcount(prev_q & ~bricks_exist);
        score_sum      = SUM_W'(score_q) + SUM_W'(kill_count);
    end

    // Next-state logic. In PLAY the checks run in priority order: death
    // zone, lost ball, cleared level, then pause. LOSE and WIN only leave
    // through reset; the unused encoding falls back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_press) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (any_death) begin
                    state_d = ST_LOSE;
                end else if (ball_lost) begin
                    state_d = last_life ? ST_LOSE : ST_LIFE_LOST;
                end else if (all_clear) begin
                    state_d = last_level ? ST_WIN : ST_LEVEL_UP;
                end else if (pause_press) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_press) begin
                    state_d = ST_PLAY;
                end
            end
            ST_LIFE_LOST: begin
                if (cnt_zero) begin
                    state_d = ST_PLAY;
                end
            end
            ST_LEVEL_UP: begin
                state_d = ST_IDLE;
            end
            ST_LOSE: begin
                state_d = ST_LOSE;
            end
            ST_WIN: begin
                state_d = ST_WIN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counters and history. Button copies and the brick history update in
    // every state so that a level reload or kills after the game ends can
    // never be mistaken for scoring kills once play resumes.
    always_comb begin
        start_dly_d = start;
        pause_dly_d = pause;
        prev_d      = bricks_exist;

        lives_d = lives_q;
        if (play_life_loss) begin
            lives_d = lives_q - LIVES_W'(1);
        end

        // The respawn counter is loaded with N-1 on entry and the exit is
        // taken on the cycle it reads zero, giving an N-cycle dwell.
        cnt_d = cnt_q;
        if (play_life_loss && !last_life) begin
            cnt_d = CNT_RELOAD;
        end else if ((state_q == ST_LIFE_LOST) && !cnt_zero) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        level_d = level_q;
        if (state_q == ST_LEVEL_UP) begin
            level_d = level_q + LEVEL_W'(1);
        end

        score_d = score_q;
        if (state_q == ST_PLAY) begin
            if (score_sum > SCORE_MAX_EXT) begin
                score_d = '1;
            end else begin
                score_d = score_sum[SCORE_W-1:0];
            end
        end
    end

    // Output logic. Level outputs follow the next state so they change on
    // the same edge as the state register; pulses are derived from the
    // transition being taken out of LIFE_LOST or LEVEL_UP.
    always_comb begin
        launch_d     = (state_d == ST_PLAY);
        game_over_d  = (state_d == ST_LOSE);
        victory_d    = (state_d == ST_WIN);
        level_load_d = (state_q == ST_LEVEL_UP);
        respawn_d    = ((state_q == ST_LIFE_LOST) && cnt_zero) ||
                       (state_q == ST_LEVEL_UP);
    end

    // State and output registers with synchronous reset. Reset restores
    // every register in one cycle, including an in-flight countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            start_dly_q  <= 1'b1;
            pause_dly_q  <= 1'b1;
            prev_q       <= '1;
            score_q      <= '0;
            lives_q      <= LIVES_W'(LIVES);
            level_q      <= '0;
            cnt_q        <= '0;
            launch_q     <= 1'b0;
            respawn_q    <= 1'b0;
            level_load_q <= 1'b0;
            game_over_q  <= 1'b0;
            victory_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_dly_q  <= start_dly_d;
            pause_dly_q  <= pause_dly_d;
            prev_q       <= prev_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            cnt_q        <= cnt_d;
            launch_q     <= launch_d;
            respawn_q    <= respawn_d;
            level_load_q <= level_load_d;
            game_over_q  <= game_over_d;
            victory_q    <= victory_d;
        end
    end

    assign launch     = launch_q;
    assign respawn    = respawn_q;
    assign level_load = level_load_q;
    assign lives_left = lives_q;
    assign level      = level_q;
    assign score      = score_q;
    assign state      = state_q;
    assign game_over  = game_over_q;
    assign victory    = victory_q;

endmodule

// File: tb/tb_game_controller.sv
// -----------------------------------------------------------------------------
// tb_game_controller
//
// Self-checking bench for game_controller. Every stimulus cycle steps a
// behavioural game model and queues the outputs it expects after the next
// clock edge; an independent monitor pops one expectation per cycle and
// compares it with the DUT. Directed scenarios are followed by random games.
// -----------------------------------------------------------------------------
module tb_game_controller;

    localparam int NB        = 6;
    localparam int LV        = 3;
    localparam int LVL       = 2;
    localparam int SW        = 3;
    localparam int RC        = 5;
    localparam int SCORE_MAX = (1 << SW) - 1;

    localparam int S_IDLE      = 0;
    localparam int S_PLAY      = 1;
    localparam int S_PAUSE     = 2;
    localparam int S_LIFE_LOST = 3;
    localparam int S_LEVEL_UP  = 4;
    localparam int S_LOSE      = 5;
    localparam int S_WIN       = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                           rst;
    logic                           start;
    logic                           pause;
    logic [NB-1:0]                  bricks_exist;
    logic [NB-1:0]                  death_zone;
    logic                           ball_lost;
    logic                           launch;
    logic                           respawn;
    logic                           level_load;
    logic [$clog2(LV+1)-1:0]        lives_left;
    logic [((LVL > 1) ? $clog2(LVL) : 1)-1:0] level;
    logic [SW-1:0]                  score;
    logic [2:0]                     state;
    logic                           game_over;
    logic                           victory;

    game_controller #(
        .N_BRICKS      (NB),
        .LIVES         (LV),
        .LEVELS        (LVL),
        .SCORE_W       (SW),
        .RESPAWN_CYCLES(RC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pause       (pause),
        .bricks_exist(bricks_exist),
        .death_zone  (death_zone),
        .ball_lost   (ball_lost),
        .launch      (launch),
        .respawn     (respawn),
        .level_load  (level_load),
        .lives_left  (lives_left),
        .level       (level),
        .score       (score),
        .state       (state),
        .game_over   (game_over),
        .victory     (victory)
    );

    typedef struct {
        int state;
        int launch;
        int respawn;
        int level_load;
        int lives;
        int level;
        int score;
        int game_over;
        int victory;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Stimulus values applied at the next negative edge.
    bit            r_rst;
    bit            r_start;
    bit            r_pause;
    bit            r_ball;
    logic [NB-1:0] r_bricks;
    logic [NB-1:0] r_dz;
    bit            reload_pending;

    // Game model state.
    int            m_state;
    int            m_lives;
    int            m_level;
    int            m_score;
    int            m_count;
    bit            m_start_prev;
    bit            m_pause_prev;
    bit            m_respawn;
    bit            m_level_load;
    logic [NB-1:0] m_prev;

    task automatic checkOutput(input string name, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Advances the game by one clock using the rules of play directly:
    // lives and levels as integers, kills counted with $countones, a
    // remaining-dwell counter for the respawn wait.
    task automatic stepModel();
        exp_t e;
        int   kills;
        bit   sp;
        bit   pp;
        if (r_rst) begin
            m_state      = S_IDLE;
            m_lives      = LV;
            m_level      = 0;
            m_score      = 0;
            m_count      = 0;
            m_start_prev = 1'b1;
            m_pause_prev = 1'b1;
            m_prev       = '1;
            m_respawn    = 1'b0;
            m_level_load = 1'b0;
        end else begin
            sp           = m_start_prev && !r_start;
            pp           = m_pause_prev && !r_pause;
            kills        = $countones(m_prev & ~r_bricks);
            m_respawn    = 1'b0;
            m_level_load = 1'b0;
            if (m_state == S_PLAY) begin
                m_score = (m_score + kills > SCORE_MAX) ? SCORE_MAX : m_score + kills;
            end
            case (m_state)
                S_IDLE: begin
                    if (sp) m_state = S_PLAY;
                end
                S_PLAY: begin
                    if (r_dz != '0) begin
                        m_state = S_LOSE;
                    end else if (r_ball) begin
                        m_lives = m_lives - 1;
                        if (m_lives == 0) begin
                            m_state = S_LOSE;
                        end else begin
                            m_state = S_LIFE_LOST;
                            m_count = RC;
                        end
                    end else if (r_bricks == '0) begin
                        m_state = (m_level == LVL - 1) ? S_WIN : S_LEVEL_UP;
                    end else if (pp) begin
                        m_state = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (pp) m_state = S_PLAY;
                end
                S_LIFE_LOST: begin
                    m_count = m_count - 1;
                    if (m_count == 0) begin
                        m_respawn = 1'b1;
                        m_state   = S_PLAY;
                    end
                end
                S_LEVEL_UP: begin
                    m_level      = m_level + 1;
                    m_level_load = 1'b1;
                    m_respawn    = 1'b1;
                    m_state      = S_IDLE;
                end
                default: begin
                end
            endcase
            m_start_prev = r_start;
            m_pause_prev = r_pause;
            m_prev       = r_bricks;
        end
        e.state      = m_state;
        e.launch     = (m_state == S_PLAY) ? 1 : 0;
        e.respawn    = m_respawn ? 1 : 0;
        e.level_load = m_level_load ? 1 : 0;
        e.lives      = m_lives;
        e.level      = m_level;
        e.score      = m_score;
        e.game_over  = (m_state == S_LOSE) ? 1 : 0;
        e.victory    = (m_state == S_WIN) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    // Drives one cycle of stimulus on the falling edge and records the
    // expected response. Bricks reload the cycle after level_load is seen,
    // as the real brick instances would.
    task automatic applyStimulus();
        @(negedge clk);
        if (reload_pending) begin
            r_bricks       = '1;
            reload_pending = 1'b0;
        end
        rst          = r_rst;
        start        = r_start;
        pause        = r_pause;
        bricks_exist = r_bricks;
        death_zone   = r_dz;
        ball_lost    = r_ball;
        stepModel();
        if (m_level_load) reload_pending = 1'b1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus();
    endtask

    task automatic doReset();
        r_rst          = 1'b1;
        r_start        = 1'b1;
        r_pause        = 1'b1;
        r_ball         = 1'b0;
        r_bricks       = '1;
        r_dz           = '0;
        reload_pending = 1'b0;
        idle(2);
        r_rst = 1'b0;
        idle(1);
    endtask

    task automatic pressStart();
        r_start = 1'b0;
        idle(2);
        r_start = 1'b1;
        idle(2);
    endtask

    task automatic pressPause();
        r_pause = 1'b0;
        idle(2);
        r_pause = 1'b1;
        idle(2);
    endtask

    // Waits until the outputs reflect the last applied stimulus.
    task automatic syncOutputs();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expectation is consumed per clock, sampled just after
    // the active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("state",      int'(state),      e.state);
                checkOutput("launch",     int'(launch),     e.launch);
                checkOutput("respawn",    int'(respawn),    e.respawn);
                checkOutput("level_load", int'(level_load), e.level_load);
                checkOutput("lives_left", int'(lives_left), e.lives);
                checkOutput("level",      int'(level),      e.level);
                checkOutput("score",      int'(score),      e.score);
                checkOutput("game_over",  int'(game_over),  e.game_over);
                checkOutput("victory",    int'(victory),    e.victory);
            end
        end
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b1;
        pause        = 1'b1;
        bricks_exist = '1;
        death_zone   = '0;
        ball_lost    = 1'b0;

        // Clear level 0 one brick per 10 cycles, pause handling, then
        // lose all three lives.
        $display("[TB] scenario: level clear, pause, lives");
        doReset();
        pressStart();
        for (int i = 0; i < NB; i++) begin
            r_bricks[i] = 1'b0;
            idle(10);
        end
        syncOutputs();
        checkOutput("lvlup_state", int'(state), S_IDLE);
        checkOutput("lvlup_level", int'(level), 1);
        checkOutput("lvlup_score", int'(score), 6);
        pressStart();
        pressPause();
        syncOutputs();
        checkOutput("pause_state", int'(state), S_PAUSE);
        checkOutput("pause_launch", int'(launch), 0);
        pressStart();
        syncOutputs();
        checkOutput("pause_start_ignored", int'(state), S_PAUSE);
        pressPause();
        syncOutputs();
        checkOutput("resume_launch", int'(launch), 1);
        for (int i = 0; i < 3; i++) begin
            r_ball = 1'b1;
            idle(1);
            r_ball = 1'b0;
            idle(10);
        end
        syncOutputs();
        checkOutput("lose_game_over", int'(game_over), 1);
        checkOutput("lose_lives", int'(lives_left), 0);

        // Death zone ends the game regardless of lives.
        $display("[TB] scenario: death zone");
        doReset();
        pressStart();
        r_dz = NB'(8);
        idle(1);
        r_dz = '0;
        idle(3);
        syncOutputs();
        checkOutput("dz_state", int'(state), S_LOSE);
        checkOutput("dz_lives", int'(lives_left), LV);

        // Reset in the middle of the respawn countdown.
        $display("[TB] scenario: reset during countdown");
        doReset();
        pressStart();
        r_ball = 1'b1;
        idle(1);
        r_ball = 1'b0;
        idle(2);
        r_rst = 1'b1;
        idle(1);
        r_rst = 1'b0;
        idle(10);
        syncOutputs();
        checkOutput("rst_cd_state", int'(state), S_IDLE);
        checkOutput("rst_cd_lives", int'(lives_left), LV);

        // Last brick with a lost ball, then saturate the score and win.
        $display("[TB] scenario: simultaneous kill and saturation");
        doReset();
        pressStart();
        for (int i = 0; i < NB - 1; i++) begin
            r_bricks[i] = 1'b0;
            idle(3);
        end
        r_bricks[NB-1] = 1'b0;
        r_ball         = 1'b1;
        idle(1);
        r_ball = 1'b0;
        idle(8);
        pressStart();
        r_bricks[1:0] = 2'b00;
        idle(3);
        r_bricks = '0;
        idle(3);
        r_bricks = '1;
        idle(3);
        syncOutputs();
        checkOutput("sat_score", int'(score), SCORE_MAX);
        checkOutput("win_victory", int'(victory), 1);
        checkOutput("win_launch", int'(launch), 0);
        checkOutput("win_lives", int'(lives_left), LV - 1);

        // Random games.
        $display("[TB] scenario: random games");
        for (int g = 0; g < 20; g++) begin
            doReset();
            pressStart();
            for (int c = 0; c < 300; c++) begin
                r_rst  = ($urandom_range(0, 999) == 0);
                r_ball = ($urandom_range(0, 39) == 0);
                r_dz   = ($urandom_range(0, 299) == 0) ? (NB'(1) << $urandom_range(0, NB - 1)) : '0;
                if ($urandom_range(0, 5) == 0) r_bricks[$urandom_range(0, NB - 1)] = 1'b0;
                if ($urandom_range(0, 7) == 0) r_start = ~r_start;
                if ($urandom_range(0, 9) == 0) r_pause = ~r_pause;
                idle(1);
            end
            r_rst = 1'b0;
        end

        syncOutputs();
        @(posedge clk);
        #3;
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
